reg_number: RTL and testbench

Four-digit entry register fed by the PS/2 keyboard receiver. Decodes numeric make codes, fills four 8-bit digit slots in typing order, and supports backspace and clear. Downstream display/compare logic reads the slots. Sits between the PS/2 receiver (`keycode`, `rx_done`) and the number-processing datapath.

---
 rtl/reg_number_pkg.sv | 40 ++++
 rtl/reg_number_ps2_digit_decode.sv | 47 ++++
 rtl/reg_number.sv | 121 ++++++++++++
 tb/tb_reg_number.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_number_pkg.sv
// reg_number_pkg
// Shared constants for the four-digit PS/2 entry register: scan codes for
// the main-row and keypad digits, the control keys, the empty-slot marker
// and the slot count. Imported by reg_number and ps2_digit_decode.
package reg_number_pkg;

  localparam int         NUM_SLOTS  = 4;
  localparam logic [7:0] SLOT_EMPTY = 8'hFF;

  // Control codes
  localparam logic [7:0] KC_BKSP  = 8'h66;
  localparam logic [7:0] KC_ESC   = 8'h76;
  localparam logic [7:0] KC_BREAK = 8'hF0;
  localparam logic [7:0] KC_EXT   = 8'hE0;

  // Main-row digit make codes
  localparam logic [7:0] KC_MAIN_0 = 8'h45;
  localparam logic [7:0] KC_MAIN_1 = 8'h16;
  localparam logic [7:0] KC_MAIN_2 = 8'h1E;
  localparam logic [7:0] KC_MAIN_3 = 8'h26;
  localparam logic [7:0] KC_MAIN_4 = 8'h25;
  localparam logic [7:0] KC_MAIN_5 = 8'h2E;
  localparam logic [7:0] KC_MAIN_6 = 8'h36;
  localparam logic [7:0] KC_MAIN_7 = 8'h3D;
  localparam logic [7:0] KC_MAIN_8 = 8'h3E;
  localparam logic [7:0] KC_MAIN_9 = 8'h46;

  // Keypad digit make codes
  localparam logic [7:0] KC_PAD_0 = 8'h70;
  localparam logic [7:0] KC_PAD_1 = 8'h69;
  localparam logic [7:0] KC_PAD_2 = 8'h72;
  localparam logic [7:0] KC_PAD_3 = 8'h7A;
  localparam logic [7:0] KC_PAD_4 = 8'h6B;
  localparam logic [7:0] KC_PAD_5 = 8'h73;
  localparam logic [7:0] KC_PAD_6 = 8'h74;
  localparam logic [7:0] KC_PAD_7 = 8'h6C;
  localparam logic [7:0] KC_PAD_8 = 8'h75;
  localparam logic [7:0] KC_PAD_9 = 8'h7D;

endpackage

// File: rtl/reg_number_ps2_digit_decode.sv
// ps2_digit_decode
// Combinational classifier for one PS/2 scan code.
// Ports:
//   keycode  in  8  scan code
//   is_digit out 1  code is a main-row or keypad digit
//   digit    out 4  decoded digit value 0-9 (0 when not a digit)
//   is_bksp  out 1  backspace code
//   is_esc   out 1  escape code
//   is_break out 1  break (release) prefix
module ps2_digit_decode
  import reg_number_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_bksp,
  output logic       is_esc,
  output logic       is_break
);

  assign is_bksp  = (keycode == KC_BKSP);
  assign is_esc   = (keycode == KC_ESC);
  assign is_break = (keycode == KC_BREAK);

  // Map both digit tables onto a 0-9 value
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (keycode)
      KC_MAIN_0, KC_PAD_0: digit = 4'd0;
      KC_MAIN_1, KC_PAD_1: digit = 4'd1;
      KC_MAIN_2, KC_PAD_2: digit = 4'd2;
      KC_MAIN_3, KC_PAD_3: digit = 4'd3;
      KC_MAIN_4, KC_PAD_4: digit = 4'd4;
      KC_MAIN_5, KC_PAD_5: digit = 4'd5;
      KC_MAIN_6, KC_PAD_6: digit = 4'd6;
      KC_MAIN_7, KC_PAD_7: digit = 4'd7;
      KC_MAIN_8, KC_PAD_8: digit = 4'd8;
      KC_MAIN_9, KC_PAD_9: digit = 4'd9;
      default: begin
        is_digit = 1'b0;
        digit    = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/reg_number.sv
// reg_number
// Four-digit entry register fed by a PS/2 receiver. Digits fill the slots
// in typing order; backspace removes the last digit, escape clears all.
// Ports:
//   clk     in  1  system clock (rising edge)
//   reset   in  1  synchronous active-high reset
//   keycode in  8  scan code, valid while rx_done=1
//   rx_done in  1  receiver data-valid (strobe or held)
//   first/second/third/fourth out 8  digit slots, 8'hFF when empty
//   count   out 3  number of filled slots 0-4
// Build option: REGNUMBER_BREAK_FILTER_EN discards the event following a
// 0xF0 break prefix so key releases never enter digits.
module reg_number
  import reg_number_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode,
  input  logic       rx_done,
  output logic [7:0] first,
  output logic [7:0] second,
  output logic [7:0] third,
  output logic [7:0] fourth,
  output logic [2:0] count
);

  logic             prev_rx_q;
  logic [7:0]       prev_kc_q;
  logic [3:0][7:0]  slots_q, slots_d;
  logic [2:0]       count_q, count_d;
  logic             event_s;
  logic             is_digit_s;
  logic [3:0]       digit_s;
  logic             is_bksp_s;
  logic             is_esc_s;
  logic             is_break_s;
  logic [2:0]       count_m1_s;

  ps2_digit_decode u_decode (
    .keycode  (keycode),
    .is_digit (is_digit_s),
    .digit    (digit_s),
    .is_bksp  (is_bksp_s),
    .is_esc   (is_esc_s),
    .is_break (is_break_s)
  );

  // A held rx_done only counts again when the code changes
  assign event_s    = rx_done & (~prev_rx_q | (keycode != prev_kc_q));
  assign count_m1_s = count_q - 3'd1;

`ifdef REGNUMBER_BREAK_FILTER_EN
  logic break_q, break_d;
`else
  logic unused_break_s;
  assign unused_break_s = is_break_s;
`endif

  // Next-state for slots, fill pointer and optional break flag
  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
`ifdef REGNUMBER_BREAK_FILTER_EN
    break_d = break_q;
`endif
    if (event_s) begin
`ifdef REGNUMBER_BREAK_FILTER_EN
      if (break_q) begin
        // Release code: swallow it whatever it is
        break_d = 1'b0;
      end else if (is_break_s) begin
        break_d = 1'b1;
      end else
`endif
      if (is_digit_s && (count_q < 3'(NUM_SLOTS))) begin
        slots_d[count_q[1:0]] = {4'd0, digit_s};
        count_d = count_q + 3'd1;
      end else if (is_bksp_s && (count_q != 3'd0)) begin
        slots_d[count_m1_s[1:0]] = SLOT_EMPTY;
        count_d = count_m1_s;
      end else if (is_esc_s) begin
        slots_d = {NUM_SLOTS{SLOT_EMPTY}};
        count_d = 3'd0;
      end else begin
        slots_d = slots_q;
        count_d = count_q;
      end
    end else begin
      slots_d = slots_q;
      count_d = count_q;
    end
  end

  // State and history registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_rx_q <= 1'b0;
      prev_kc_q <= 8'h00;
      slots_q   <= {NUM_SLOTS{SLOT_EMPTY}};
      count_q   <= 3'd0;
`ifdef REGNUMBER_BREAK_FILTER_EN
      break_q   <= 1'b0;
`endif
    end else begin
      prev_rx_q <= rx_done;
      prev_kc_q <= keycode;
      slots_q   <= slots_d;
      count_q   <= count_d;
`ifdef REGNUMBER_BREAK_FILTER_EN
      break_q   <= break_d;
`endif
    end
  end

  assign first  = slots_q[0];
  assign second = slots_q[1];
  assign third  = slots_q[2];
  assign fourth = slots_q[3];
  assign count  = count_q;

endmodule

// File: tb/tb_reg_number.sv
// tb_reg_number
// Scoreboard bench for reg_number: the stimulus process updates a queue-based
// reference model at every rising edge and pushes the expected outputs; a
// monitor pops and compares at the following falling edge.
module tb_reg_number;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keycode;
  logic       rx_done;
  logic [7:0] first, second, third, fourth;
  logic [2:0] count;

  reg_number dut (
    .clk     (clk),
    .reset   (reset),
    .keycode (keycode),
    .rx_done (rx_done),
    .first   (first),
    .second  (second),
    .third   (third),
    .fourth  (fourth),
    .count   (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s0, s1, s2, s3;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int         digits[$];
  bit         m_prev_rx = 1'b0;
  logic [7:0] m_prev_kc = 8'h00;
  bit         m_brk = 1'b0;

  function automatic int decode(logic [7:0] k);
    logic [7:0] main_t [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pad_t  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    for (int i = 0; i < 10; i++) begin
      if (k == main_t[i] || k == pad_t[i]) return i;
    end
    return -1;
  endfunction

  task automatic apply_code(logic [7:0] k);
    int d;
    d = decode(k);
    if (d >= 0) begin
      if (digits.size() < 4) digits.push_back(d);
    end else if (k == 8'h66) begin
      if (digits.size() > 0) void'(digits.pop_back());
    end else if (k == 8'h76) begin
      digits.delete();
    end
  endtask

  task automatic model_edge(bit r, bit rx, logic [7:0] k);
    bit   ev;
    exp_t e;
    if (r) begin
      digits.delete();
      m_brk     = 1'b0;
      m_prev_rx = 1'b0;
      m_prev_kc = 8'h00;
    end else begin
      ev = rx && (!m_prev_rx || k != m_prev_kc);
      m_prev_rx = rx;
      m_prev_kc = k;
      if (ev) begin
`ifdef REGNUMBER_BREAK_FILTER_EN
        if (m_brk) m_brk = 1'b0;
        else if (k == 8'hF0) m_brk = 1'b1;
        else apply_code(k);
`else
        apply_code(k);
`endif
      end
    end
    e.s0  = (digits.size() > 0) ? 8'(digits[0]) : 8'hFF;
    e.s1  = (digits.size() > 1) ? 8'(digits[1]) : 8'hFF;
    e.s2  = (digits.size() > 2) ? 8'(digits[2]) : 8'hFF;
    e.s3  = (digits.size() > 3) ? 8'(digits[3]) : 8'hFF;
    e.cnt = 3'(digits.size());
    exp_q.push_back(e);
  endtask

  task automatic step(bit r, bit rx, logic [7:0] k);
    reset   = r;
    rx_done = rx;
    keycode = k;
    @(posedge clk);
    model_edge(r, rx, k);
    @(negedge clk);
  endtask

  task automatic hold(bit rx, logic [7:0] k, int n);
    for (int i = 0; i < n; i++) step(1'b0, rx, k);
  endtask

  task automatic strobe(logic [7:0] k);
    step(1'b0, 1'b1, k);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest expected snapshot
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("first",  int'(first),  int'(e.s0));
        chk("second", int'(second), int'(e.s1));
        chk("third",  int'(third),  int'(e.s2));
        chk("fourth", int'(fourth), int'(e.s3));
        chk("count",  int'(count),  int'(e.cnt));
      end
    end
  end

  logic [7:0] pool [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h46, 8'h70,
                            8'h7D, 8'h73, 8'h66, 8'h66, 8'h76, 8'hF0,
                            8'hE0, 8'h1C, 8'h00, 8'h5A};

  initial begin
    reset = 1'b1; rx_done = 1'b0; keycode = 8'h00;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00);

    // Held rx_done, code stepping every 2 cycles
    hold(1'b1, 8'h16, 2); hold(1'b1, 8'h1E, 2);
    hold(1'b1, 8'h26, 2); hold(1'b1, 8'h25, 2);
    // Full register, backspace, refill
    hold(1'b1, 8'h46, 2); hold(1'b0, 8'h00, 1);
    strobe(8'h66); strobe(8'h46);
    // Repeated code needs rx_done to drop
    step(1'b1, 1'b0, 8'h00);
    strobe(8'h45); strobe(8'h45);
    step(1'b1, 1'b0, 8'h00);
    hold(1'b1, 8'h45, 4); hold(1'b0, 8'h00, 1);
    // Break prefix sequence
    step(1'b1, 1'b0, 8'h00);
    strobe(8'h16); strobe(8'hF0); strobe(8'h16);
    // Escape and an unrelated code
    step(1'b1, 1'b0, 8'h00);
    strobe(8'h16); strobe(8'h72); strobe(8'h7A);
    strobe(8'h76); strobe(8'h1C);
    // Reset beats a simultaneous digit event
    strobe(8'h3D); strobe(8'h3E);
    step(1'b1, 1'b1, 8'h26);
    hold(1'b1, 8'h26, 2); hold(1'b0, 8'h00, 1);
    // Backspace on empty register
    strobe(8'h66); strobe(8'h66); strobe(8'h74);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit         r;
      bit         rx;
      logic [7:0] k;
      r  = ($urandom_range(0, 99) == 0);
      rx = ($urandom_range(0, 3) != 0);
      k  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 2) == 0) k = keycode;
      step(r, rx, k);
    end

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
